// File: rtl/amba3_apb_slave_pkg.sv
// pkg_amba3: shared widths, key-offset helper and storage record for the APB sparse memory.
package pkg_amba3;
    localparam int DEF_ADDR_SIZE = 32;
    localparam int DEF_DATA_SIZE = 32;

    // Number of byte-lane bits dropped from paddr to form the word key.
    function automatic int data_base(input int data_size);
        return $clog2(data_size / 8);
    endfunction

    localparam int DATA_BASE = data_base(DEF_DATA_SIZE);

    typedef logic [DEF_ADDR_SIZE-1:0] addr_t;
    typedef logic [DEF_DATA_SIZE-1:0] data_t;

    typedef struct packed {
        logic valid;
        logic [DEF_ADDR_SIZE-DATA_BASE-1:0] key;
        data_t data;
    } entry_t;

    typedef enum logic {PH_IDLE, PH_ACCESS} phase_t;
endpackage

// File: rtl/amba3_apb_slave_if.sv
// amba3_apb_slave_if: APB bus signals between a requester and the sparse-memory completer.
interface amba3_apb_slave_if #(
    parameter int ADDR_SIZE = pkg_amba3::DEF_ADDR_SIZE,
    parameter int DATA_SIZE = pkg_amba3::DEF_DATA_SIZE
);
    logic psel;
    logic penable;
    logic pwrite;
    logic [ADDR_SIZE-1:0] paddr;
    logic [DATA_SIZE-1:0] pwdata;
    logic [DATA_SIZE-1:0] prdata;
    logic pready;
    logic pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/amba3_apb_slave_cam.sv
// amba3_apb_cam: fully associative word store with key match, first-free search and write port.
module amba3_apb_cam #(
    parameter int KEY_SIZE = 30,
    parameter int DATA_SIZE = 32,
    parameter int DEPTH = 64,
    parameter int IDX_SIZE = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic [KEY_SIZE-1:0] key,
    output logic hit,
    output logic [IDX_SIZE-1:0] hit_idx,
    output logic free,
    output logic [IDX_SIZE-1:0] free_idx,
    output logic [DATA_SIZE-1:0] rdata,
    input  logic we,
    input  logic [IDX_SIZE-1:0] widx,
    input  logic [DATA_SIZE-1:0] wdata
);
    logic [DEPTH-1:0] valid;
    logic [KEY_SIZE-1:0] keys [DEPTH];
    logic [DATA_SIZE-1:0] data [DEPTH];

    // Scan high to low so the lowest matching/invalid index wins.
    always_comb begin
        hit = 1'b0;
        hit_idx = '0;
        free = 1'b0;
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid[i] && keys[i] == key) begin
                hit = 1'b1;
                hit_idx = IDX_SIZE'(i);
            end
            if (!valid[i]) begin
                free = 1'b1;
                free_idx = IDX_SIZE'(i);
            end
        end
    end

    assign rdata = hit ? data[hit_idx] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            valid <= '0;
        else if (we)
            valid[widx] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (we) begin
            keys[widx] <= key;
            data[widx] <= wdata;
        end
    end
endmodule

// File: rtl/amba3_apb_slave.sv
// amba3_apb_slave: APB3 completer with fixed wait states backed by a sparse associative word store.
module amba3_apb_slave #(
    parameter int ADDR_SIZE = pkg_amba3::DEF_ADDR_SIZE,
    parameter int DATA_SIZE = pkg_amba3::DEF_DATA_SIZE,
    parameter int DEPTH = 64,
    parameter int WAIT_STATES = 0
) (
    input logic pclk,
    input logic preset,
    amba3_apb_slave_if.slave apb
);
    import pkg_amba3::*;

    localparam int BASE = data_base(DATA_SIZE);
    localparam int KEY_SIZE = ADDR_SIZE - BASE;
    localparam int IDX_SIZE = DEPTH > 1 ? $clog2(DEPTH) : 1;

    if (DATA_SIZE != 8 && DATA_SIZE != 16 && DATA_SIZE != 32 && DATA_SIZE != 64) begin : g_bad_data
        $error("DATA_SIZE must be 8, 16, 32 or 64");
    end
    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait
        $error("WAIT_STATES must be 0..15");
    end

    phase_t state, state_nx;
    logic [3:0] count, count_nx;
    logic setup, access, commit, hit, free;
    logic [IDX_SIZE-1:0] hit_idx, free_idx;
    logic [KEY_SIZE-1:0] key;
    logic [DATA_SIZE-1:0] rdata, rdata_q;
    logic unused_addr;

    assign key = apb.paddr[ADDR_SIZE-1:BASE];
    assign unused_addr = ^apb.paddr;
    assign apb.prdata = rdata_q;

    // Access cycles only count once a setup phase has been seen, so reset or a stray penable never raises pready.
    always_comb begin
        setup = apb.psel & ~apb.penable;
        access = apb.psel & apb.penable & (state == PH_ACCESS);
        apb.pready = access & (count == 4'(WAIT_STATES));
        apb.pslverr = apb.pready & apb.pwrite & ~hit & ~free;
        commit = apb.pready & apb.pwrite & (hit | free);
        state_nx = setup ? PH_ACCESS : (apb.pready | ~apb.psel) ? PH_IDLE : state;
        count_nx = (setup | apb.pready) ? 4'd0 : access ? count + 4'd1 : count;
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state <= PH_IDLE;
            count <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nx;
            count <= count_nx;
            if (setup & ~apb.pwrite)
                rdata_q <= rdata;
        end
    end

    amba3_apb_cam #(
        .KEY_SIZE(KEY_SIZE),
        .DATA_SIZE(DATA_SIZE),
        .DEPTH(DEPTH),
        .IDX_SIZE(IDX_SIZE)
    ) u_cam (
        .clk(pclk),
        .rst(preset),
        .key(key),
        .hit(hit),
        .hit_idx(hit_idx),
        .free(free),
        .free_idx(free_idx),
        .rdata(rdata),
        .we(commit),
        .widx(hit ? hit_idx : free_idx),
        .wdata(apb.pwdata)
    );
endmodule

// File: tb/tb_amba3_apb_slave.sv
// tb_amba3_apb_slave: table, random and hand-written sequences against two completer instances.
module tb_amba3_apb_slave;
    localparam int DEPTH0 = 64;

    logic pclk = 1'b0;
    logic rst0 = 1'b1;
    logic rst3 = 1'b1;
    logic tgt = 1'b0;
    logic psel = 1'b0;
    logic penable = 1'b0;
    logic pwrite = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic pready, pslverr;

    int n_pass = 0;
    int n_chk = 0;

    amba3_apb_slave_if bus0 ();
    amba3_apb_slave_if bus3 ();

    assign bus0.psel = psel & ~tgt;
    assign bus3.psel = psel & tgt;
    assign bus0.penable = penable;
    assign bus3.penable = penable;
    assign bus0.pwrite = pwrite;
    assign bus3.pwrite = pwrite;
    assign bus0.paddr = paddr;
    assign bus3.paddr = paddr;
    assign bus0.pwdata = pwdata;
    assign bus3.pwdata = pwdata;
    assign prdata = tgt ? bus3.prdata : bus0.prdata;
    assign pready = tgt ? bus3.pready : bus0.pready;
    assign pslverr = tgt ? bus3.pslverr : bus0.pslverr;

    amba3_apb_slave #(.DEPTH(DEPTH0), .WAIT_STATES(0)) u_dut0 (.pclk(pclk), .preset(rst0), .apb(bus0));
    amba3_apb_slave #(.DEPTH(4), .WAIT_STATES(3)) u_dut3 (.pclk(pclk), .preset(rst3), .apb(bus3));

    always #5 pclk = ~pclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    // Reference model: word-keyed associative memory with a capacity limit and no eviction.
    logic [31:0] mem [int unsigned];

    function automatic bit model_write(logic [31:0] a, logic [31:0] d);
        int unsigned k = a >> 2;
        if (mem.exists(k) || mem.num() < DEPTH0) begin
            mem[k] = d;
            return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [31:0] model_read(logic [31:0] a);
        int unsigned k = a >> 2;
        return mem.exists(k) ? mem[k] : 32'h0;
    endfunction

    task automatic xfer(input bit w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic err, output int lat);
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
        @(negedge pclk);
        penable = 1'b1;
        lat = 1;
        #1;
        while (!pready && lat < 32) begin
            @(negedge pclk);
            lat++;
            #1;
        end
        check("pready_within_bound", pready, 1);
        rd = prdata;
        err = pslverr;
        @(posedge pclk);
        #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    // Cycle-by-cycle view of a WAIT_STATES=3 transfer: pready only on the 4th access cycle.
    task automatic xfer_mon(input bit w, input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] exp, input bit exp_err, input string tag);
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
        @(negedge pclk);
        penable = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            #1;
            check($sformatf("%s_pready_c%0d", tag, k), pready, k == 4);
            check($sformatf("%s_pslverr_c%0d", tag, k), pslverr, k == 4 ? exp_err : 1'b0);
            if (!w) check($sformatf("%s_prdata_c%0d", tag, k), prdata, exp);
            if (k < 4) @(negedge pclk);
        end
        @(posedge pclk);
        #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    typedef struct {
        bit w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
        bit err;
        bit idle;
    } vec_t;

    vec_t tbl[15];

    initial begin
        logic [31:0] rd, a, d;
        logic err;
        bit e;
        int lat;
        int unsigned q[$];

        tbl[0]  = '{1'b1, 32'h0800, 32'h00040000, 32'h0, 1'b0, 1'b1};
        tbl[1]  = '{1'b1, 32'h0040, 32'h80003333, 32'h0, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 32'h0084, 32'h04400011, 32'h0, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 32'h0140, 32'h0000001C, 32'h0, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 32'h0040, 32'h0, 32'h80003333, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 32'h0140, 32'h0, 32'h0000001C, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 32'h0800, 32'h0, 32'h00040000, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 32'h0084, 32'h0, 32'h04400011, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 32'h0040, 32'h12345678, 32'h0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 32'h0084, 32'h40506070, 32'h0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 32'h0018, 32'h22446688, 32'h0, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 32'h0018, 32'h0, 32'h22446688, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 32'h0040, 32'h0, 32'h12345678, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 32'h0084, 32'h0, 32'h40506070, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 32'h1000, 32'h0, 32'h0, 1'b0, 1'b1};

        // Reset with a full access request on the bus: outputs stay at reset values.
        psel = 1'b1; penable = 1'b1;
        #12;
        check("rst_pready", pready, 0);
        check("rst_pslverr", pslverr, 0);
        check("rst_prdata", prdata, 0);
        psel = 1'b0; penable = 1'b0;
        @(negedge pclk);
        rst0 = 1'b0; rst3 = 1'b0;
        @(negedge pclk);
        penable = 1'b1;
        #1;
        check("penable_no_psel_pready", pready, 0);
        @(negedge pclk);
        penable = 1'b0;

        for (int i = 0; i < 15; i++) begin
            if (tbl[i].idle) repeat ($urandom_range(0, 10)) @(negedge pclk);
            xfer(tbl[i].w, tbl[i].a, tbl[i].d, rd, err, lat);
            check($sformatf("tbl%0d_latency", i), lat, 1);
            check($sformatf("tbl%0d_pslverr", i), err, tbl[i].err);
            if (!tbl[i].w) check($sformatf("tbl%0d_prdata", i), rd, tbl[i].exp);
            else e = model_write(tbl[i].a, tbl[i].d);
        end

        xfer(1'b1, 32'h0043, 32'hA5A5A5A5, rd, err, lat);
        e = model_write(32'h0043, 32'hA5A5A5A5);
        check("lowbits_wr_err", err, 0);
        xfer(1'b0, 32'h0040, 32'h0, rd, err, lat);
        check("lowbits_rd", rd, 32'hA5A5A5A5);
        repeat (3) @(negedge pclk);
        check("prdata_hold_idle", prdata, 32'hA5A5A5A5);
        xfer(1'b1, 32'h0200, 32'h00000001, rd, err, lat);
        e = model_write(32'h0200, 32'h00000001);
        check("prdata_hold_write", prdata, 32'hA5A5A5A5);

        while (mem.num() < DEPTH0) begin
            a = $urandom & 32'hFFFF_FFFC;
            if (mem.exists(a >> 2)) continue;
            d = $urandom;
            repeat ($urandom_range(0, 10)) @(negedge pclk);
            e = model_write(a, d);
            xfer(1'b1, a, d, rd, err, lat);
            check("fill_pslverr", err, e);
        end

        foreach (mem[k]) q.push_back(k);
        for (int i = q.size() - 1; i > 0; i--) begin
            int j = $urandom_range(0, i);
            int unsigned t = q[i];
            q[i] = q[j];
            q[j] = t;
        end
        foreach (q[i]) begin
            a = q[i] << 2;
            repeat ($urandom_range(0, 10)) @(negedge pclk);
            xfer(1'b0, a, 32'h0, rd, err, lat);
            check($sformatf("readback_%h", a), rd, model_read(a));
            check("readback_pslverr", err, 0);
        end

        do a = $urandom & 32'hFFFF_FFFC; while (mem.exists(a >> 2));
        e = model_write(a, 32'hDEADBEEF);
        xfer(1'b1, a, 32'hDEADBEEF, rd, err, lat);
        check("full_write_pslverr", err, e);
        xfer(1'b0, a, 32'h0, rd, err, lat);
        check("full_miss_read", rd, model_read(a));
        check("full_miss_pslverr", err, 0);
        a = q[0] << 2;
        e = model_write(a, 32'h5A5A0F0F);
        xfer(1'b1, a, 32'h5A5A0F0F, rd, err, lat);
        check("full_overwrite_pslverr", err, e);
        xfer(1'b0, a, 32'h0, rd, err, lat);
        check("full_overwrite_read", rd, model_read(a));

        tgt = 1'b1;
        xfer_mon(1'b1, 32'h0010, 32'hCAFEF00D, 32'h0, 1'b0, "ws3_wr");
        xfer_mon(1'b0, 32'h0010, 32'h0, 32'hCAFEF00D, 1'b0, "ws3_rd");

        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0010; pwdata = 32'h11111111;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        #2;
        rst3 = 1'b1;
        #1;
        check("midrst_pready", pready, 0);
        check("midrst_pslverr", pslverr, 0);
        check("midrst_prdata", prdata, 0);
        psel = 1'b0; penable = 1'b0;
        repeat (2) @(negedge pclk);
        rst3 = 1'b0;

        xfer_mon(1'b0, 32'h0010, 32'h0, 32'h0, 1'b0, "ws3_empty");
        for (int i = 1; i <= 4; i++)
            xfer_mon(1'b1, 32'(i * 16), 32'(i * 32'h01010101), 32'h0, 1'b0, $sformatf("ws3_fill%0d", i));
        xfer_mon(1'b1, 32'h0050, 32'h77777777, 32'h0, 1'b1, "ws3_full");
        xfer_mon(1'b0, 32'h0050, 32'h0, 32'h0, 1'b0, "ws3_full_rd");
        xfer_mon(1'b0, 32'h0030, 32'h0, 32'h03030303, 1'b0, "ws3_hit_rd");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
